// File: rtl/bus_pkg.sv
// Memory map defaults, window-size helpers and FSM state encoding shared by the bus controller.
package bus_pkg;

    localparam int unsigned FLASH_WIDTH_DFLT = 9;
    localparam int unsigned RAM_WIDTH_DFLT   = 10;
    localparam logic [31:0] FLASH_BASE_DFLT  = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE_DFLT    = 32'h1000_0000;

    // Flash is word addressed, so its byte window is four times its word count.
    function automatic logic [31:0] flash_win_bytes(input int unsigned fw);
        return 32'(4) << fw;
    endfunction

    function automatic logic [31:0] ram_win_bytes(input int unsigned rw);
        return 32'(1) << rw;
    endfunction

    localparam logic [31:0] FLASH_SIZE_DFLT = flash_win_bytes(FLASH_WIDTH_DFLT);
    localparam logic [31:0] RAM_SIZE_DFLT   = ram_win_bytes(RAM_WIDTH_DFLT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLASH_RD = 3'd1,
        RAM_RD   = 3'd2,
        RAM_WR   = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational window hit and fault classification of a CPU access.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned FLASH_WIDTH = FLASH_WIDTH_DFLT,
    parameter int unsigned RAM_WIDTH   = RAM_WIDTH_DFLT,
    parameter logic [31:0] FLASH_BASE  = FLASH_BASE_DFLT,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DFLT
) (
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        size_i,
    output logic        flash_hit_c_o,
    output logic        ram_hit_c_o,
    output logic        fault_c_o
);

    localparam logic [31:0] FLASH_SIZE = flash_win_bytes(FLASH_WIDTH);
    localparam logic [31:0] RAM_SIZE   = ram_win_bytes(RAM_WIDTH);

    logic [31:0] flash_off;
    logic [31:0] ram_off;

    // Offsets wrap below the base, so a single unsigned compare covers both bounds.
    always_comb begin
        flash_off     = addr_i - FLASH_BASE;
        ram_off       = addr_i - RAM_BASE;
        flash_hit_c_o = (flash_off < FLASH_SIZE);
        ram_hit_c_o   = (ram_off < RAM_SIZE) && !flash_hit_c_o;
        fault_c_o     = !(flash_hit_c_o || ram_hit_c_o)
                      || (flash_hit_c_o && we_i)
                      || (size_i && (addr_i[1:0] != 2'b00));
    end

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus controller bridging to a combinational word flash and a synchronous byte RAM.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned FLASH_WIDTH = FLASH_WIDTH_DFLT,
    parameter int unsigned RAM_WIDTH   = RAM_WIDTH_DFLT,
    parameter logic [31:0] FLASH_BASE  = FLASH_BASE_DFLT,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic                   size,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ack,
    output logic                   err,
    output logic [FLASH_WIDTH-1:0] flash_addr,
    input  logic [31:0]            flash_data,
    output logic                   ram_rw,
    output logic [RAM_WIDTH-1:0]   ram_addr,
    output logic [7:0]             ram_di,
    input  logic [7:0]             ram_do
);

    state_e      state_q;
    logic        size_q;
    logic [1:0]  bsel_q;
    logic [31:0] wdata_q;
    logic [2:0]  cnt_q;
    logic [23:0] rbuf_q;

    logic        dec_flash;
    logic        dec_ram;
    logic        dec_fault;
    logic [2:0]  nbytes;
    logic [1:0]  wr_idx;

    bus_addr_decode #(
        .FLASH_WIDTH (FLASH_WIDTH),
        .RAM_WIDTH   (RAM_WIDTH),
        .FLASH_BASE  (FLASH_BASE),
        .RAM_BASE    (RAM_BASE)
    ) u_decode (
        .addr_i        (addr),
        .we_i          (we),
        .size_i        (size),
        .flash_hit_c_o (dec_flash),
        .ram_hit_c_o   (dec_ram),
        .fault_c_o     (dec_fault)
    );

    assign nbytes = size_q ? 3'd4 : 3'd1;
    assign wr_idx = 2'(cnt_q + 3'd1);

    // Cycle-1 memory signals are loaded at the acceptance edge so every output stays registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            size_q     <= 1'b0;
            bsel_q     <= 2'b00;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            rdata      <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            flash_addr <= '0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        size_q  <= size;
                        bsel_q  <= addr[1:0];
                        wdata_q <= wdata;
                        cnt_q   <= '0;
                        if (dec_fault) begin
                            ack     <= 1'b1;
                            err     <= 1'b1;
                            state_q <= DONE;
                        end else if (dec_flash) begin
                            flash_addr <= addr[FLASH_WIDTH+1:2];
                            state_q    <= FLASH_RD;
                        end else if (dec_ram) begin
                            ram_addr <= addr[RAM_WIDTH-1:0];
                            if (we) begin
                                ram_rw  <= 1'b1;
                                ram_di  <= wdata[7:0];
                                state_q <= RAM_WR;
                            end else begin
                                state_q <= RAM_RD;
                            end
                        end
                    end
                end
                FLASH_RD: begin
                    rdata   <= size_q ? flash_data : {24'h0, flash_data[8*bsel_q +: 8]};
                    ack     <= 1'b1;
                    state_q <= DONE;
                end
                // RAM data lags its address by one cycle; cnt_q counts cycles spent in this state.
                RAM_RD: begin
                    if (cnt_q == nbytes) begin
                        rdata   <= size_q ? {ram_do, rbuf_q} : {24'h0, ram_do};
                        ack     <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            rbuf_q <= {ram_do, rbuf_q[23:8]};
                        end
                        ram_addr <= ram_addr + RAM_WIDTH'(1);
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                RAM_WR: begin
                    if (cnt_q == nbytes - 3'd1) begin
                        ram_rw  <= 1'b0;
                        ack     <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ram_addr <= ram_addr + RAM_WIDTH'(1);
                        ram_di   <= wdata_q[8*wr_idx +: 8];
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                DONE: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl with a combinational flash model and a one-cycle-latency byte RAM model.
module tb_bus_ctrl;

    localparam int unsigned FW = 9;
    localparam int unsigned RW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic          size;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          err;
    logic [FW-1:0] flash_addr;
    logic [31:0]   flash_data;
    logic          ram_rw;
    logic [RW-1:0] ram_addr;
    logic [7:0]    ram_di;
    logic [7:0]    ram_do;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] flash_mem [0:511];
    logic [7:0]  ram_mem   [0:1023];

    logic          log_rw    [1:20];
    logic [RW-1:0] log_addr  [1:20];
    logic [7:0]    log_di    [1:20];
    logic [FW-1:0] log_faddr [1:20];
    int            t_ack;
    int            t_rw;
    int            t_bad;
    logic          t_err;
    logic [31:0]   t_rdata;

    always #5 clk = ~clk;

    bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
        .err        (err),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_do     (ram_do)
    );

    assign flash_data = flash_mem[flash_addr];

    always @(posedge clk) begin
        if (ram_rw) ram_mem[ram_addr] <= ram_di;
        ram_do <= ram_mem[ram_addr];
    end

    // One transaction starting in the next IDLE cycle; logs per-cycle bus activity until ack or timeout.
    task automatic do_txn(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        t_ack = -1; t_rw = 0; t_bad = 0; t_err = 1'b0; t_rdata = '0;
        for (int k = 1; k <= 20 && t_ack < 0; k++) begin
            @(negedge clk);
            log_rw[k]    = ram_rw;
            log_addr[k]  = ram_addr;
            log_di[k]    = ram_di;
            log_faddr[k] = flash_addr;
            if (ram_rw) t_rw++;
            if (err && !ack) t_bad++;
            if (ack) begin
                t_ack   = k;
                t_err   = err;
                t_rdata = rdata;
                req     = 1'b0;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (ram_rw !== 1'b0) begin n_fail++; $display("FAIL reset_ram_rw got=%b exp=0", ram_rw); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        n_checks++; if (ram_di !== 8'h0) begin n_fail++; $display("FAIL reset_ram_di got=%h exp=0", ram_di); end
        n_checks++; if (flash_addr !== '0) begin n_fail++; $display("FAIL reset_flash_addr got=%h exp=0", flash_addr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flash_read();
        do_txn(1'b0, 1'b1, 32'h0000_000C, 32'h0);
        n_checks++; if (log_faddr[1] !== 9'd3) begin n_fail++; $display("FAIL flash_word_addr got=%0d exp=3", log_faddr[1]); end
        n_checks++; if (t_ack !== 2) begin n_fail++; $display("FAIL flash_word_ack_cycle got=%0d exp=2", t_ack); end
        n_checks++; if (t_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flash_word_rdata got=%h exp=deadbeef", t_rdata); end
        n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL flash_word_err got=%b exp=0", t_err); end
        n_checks++; if (t_rw !== 0) begin n_fail++; $display("FAIL flash_word_ram_rw got=%0d exp=0", t_rw); end
        do_txn(1'b0, 1'b0, 32'h0000_000D, 32'h0);
        n_checks++; if (t_ack !== 2) begin n_fail++; $display("FAIL flash_byte_ack_cycle got=%0d exp=2", t_ack); end
        n_checks++; if (t_rdata !== 32'h0000_00BE) begin n_fail++; $display("FAIL flash_byte_rdata got=%h exp=000000be", t_rdata); end
    endtask

    task automatic test_ram_word();
        logic [7:0] exp_di [0:3];
        exp_di[0] = 8'h44; exp_di[1] = 8'h33; exp_di[2] = 8'h22; exp_di[3] = 8'h11;
        do_txn(1'b1, 1'b1, 32'h1000_0010, 32'h1122_3344);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (log_rw[k] !== 1'b1 || log_addr[k] !== RW'(32'h10 + k - 1) || log_di[k] !== exp_di[k-1]) begin
                n_fail++;
                $display("FAIL ram_word_wr_cycle%0d got rw=%b addr=%h di=%h exp rw=1 addr=%h di=%h",
                         k, log_rw[k], log_addr[k], log_di[k], RW'(32'h10 + k - 1), exp_di[k-1]);
            end
        end
        n_checks++; if (t_ack !== 5) begin n_fail++; $display("FAIL ram_word_wr_ack_cycle got=%0d exp=5", t_ack); end
        n_checks++; if (t_rw !== 4) begin n_fail++; $display("FAIL ram_word_wr_pulses got=%0d exp=4", t_rw); end
        n_checks++; if (t_rdata !== 32'h0000_00BE) begin n_fail++; $display("FAIL ram_word_wr_rdata_hold got=%h exp=000000be", t_rdata); end
        do_txn(1'b0, 1'b1, 32'h1000_0010, 32'h0);
        n_checks++; if (t_ack !== 6) begin n_fail++; $display("FAIL ram_word_rd_ack_cycle got=%0d exp=6", t_ack); end
        n_checks++; if (t_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL ram_word_rd_rdata got=%h exp=11223344", t_rdata); end
        n_checks++; if (t_bad !== 0) begin n_fail++; $display("FAIL ram_word_err_without_ack got=%0d exp=0", t_bad); end
    endtask

    task automatic test_ram_byte();
        do_txn(1'b1, 1'b0, 32'h1000_03FF, 32'hFFFF_FFA5);
        n_checks++; if (t_ack !== 2) begin n_fail++; $display("FAIL ram_byte_wr_ack_cycle got=%0d exp=2", t_ack); end
        n_checks++; if (t_rw !== 1 || log_addr[1] !== 10'h3FF || log_di[1] !== 8'hA5) begin
            n_fail++; $display("FAIL ram_byte_wr_bus got pulses=%0d addr=%h di=%h exp pulses=1 addr=3ff di=a5", t_rw, log_addr[1], log_di[1]);
        end
        do_txn(1'b0, 1'b0, 32'h1000_03FF, 32'h0);
        n_checks++; if (t_ack !== 3) begin n_fail++; $display("FAIL ram_byte_rd_ack_cycle got=%0d exp=3", t_ack); end
        n_checks++; if (t_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL ram_byte_rd_rdata got=%h exp=000000a5", t_rdata); end
    endtask

    task automatic test_errors();
        logic        e_we   [0:2];
        logic        e_size [0:2];
        logic [31:0] e_addr [0:2];
        e_we[0] = 1'b1; e_size[0] = 1'b1; e_addr[0] = 32'h0000_0004;
        e_we[1] = 1'b0; e_size[1] = 1'b1; e_addr[1] = 32'h1000_0002;
        e_we[2] = 1'b1; e_size[2] = 1'b0; e_addr[2] = 32'h2000_0000;
        for (int i = 0; i < 3; i++) begin
            do_txn(e_we[i], e_size[i], e_addr[i], 32'h5A5A_5A5A);
            n_checks++; if (t_ack !== 1 || t_err !== 1'b1) begin
                n_fail++; $display("FAIL error_%0d_ack got cycle=%0d err=%b exp cycle=1 err=1", i, t_ack, t_err);
            end
            n_checks++; if (t_rw !== 0) begin n_fail++; $display("FAIL error_%0d_ram_rw got=%0d exp=0", i, t_rw); end
            n_checks++; if (t_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL error_%0d_rdata_hold got=%h exp=000000a5", i, t_rdata); end
        end
    endtask

    task automatic test_reset_mid();
        do_txn(1'b1, 1'b1, 32'h1000_0020, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 1'b1; addr = 32'h1000_0020; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++; if (ram_rw !== 1'b1 || ram_di !== 8'h0D) begin
            n_fail++; $display("FAIL reset_mid_cycle1 got rw=%b di=%h exp rw=1 di=0d", ram_rw, ram_di);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ram_rw !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ram_rw got=%b exp=0", ram_rw); end
        n_checks++; if (ram_addr !== '0 || ram_di !== 8'h0 || ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs got addr=%h di=%h ack=%b exp 0", ram_addr, ram_di, ack);
        end
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        do_txn(1'b0, 1'b1, 32'h1000_0020, 32'h0);
        n_checks++; if (t_ack !== 6) begin n_fail++; $display("FAIL reset_mid_read_ack_cycle got=%0d exp=6", t_ack); end
        n_checks++; if (t_rdata !== 32'h0000_000D) begin n_fail++; $display("FAIL reset_mid_read_rdata got=%h exp=0000000d", t_rdata); end
    endtask

    task automatic test_back_to_back();
        logic        ack_log [1:7];
        int          n_ack;
        logic [31:0] r2;
        n_ack = 0;
        r2    = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h0000_000C; wdata = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            ack_log[k] = ack;
            if (ack) n_ack++;
            if (k == 2) addr = 32'h0000_0010;
            if (k == 5) begin
                r2  = rdata;
                req = 1'b0;
            end
        end
        n_checks++; if (ack_log[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack got=%b exp=1", ack_log[2]); end
        n_checks++; if (ack_log[3] !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup_ack got=%b exp=0", ack_log[3]); end
        n_checks++; if (ack_log[5] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack got=%b exp=1", ack_log[5]); end
        n_checks++; if (n_ack !== 2) begin n_fail++; $display("FAIL b2b_ack_count got=%0d exp=2", n_ack); end
        n_checks++; if (r2 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_second_rdata got=%h exp=0badf00d", r2); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) flash_mem[i] = 32'h0;
        flash_mem[3] = 32'hDEAD_BEEF;
        flash_mem[4] = 32'h0BAD_F00D;
        test_reset();
        test_flash_read();
        test_ram_word();
        test_ram_byte();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
